// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: shared constants, FSM state type and key-length helper for the AES SPI sequencer
package aes_spi_pkg;
    localparam logic       MODE_ENCR = 1'b0;
    localparam logic       MODE_DECR = 1'b1;
    localparam logic [1:0] SIZE_128  = 2'b00;
    localparam logic [1:0] SIZE_192  = 2'b01;
    localparam logic [1:0] SIZE_256  = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_MSG,
        ST_KEY,
        ST_WAIT,
        ST_RECV,
        ST_DONE
    } state_t;

    function automatic logic [8:0] key_len(input logic [1:0] size);
        return size == SIZE_256 ? 9'd256 : size == SIZE_192 ? 9'd192 : 9'd128;
    endfunction
endpackage

// File: rtl/aes_spi_sclk_gen.sv
// aes_spi_sclk_gen: SCLK divider; toggles every CLK_DIV clk while enabled, idles low otherwise
//   clk, reset     : system clock, synchronous active-high reset
//   i_en           : count enable (sequencer not idle)
//   o_sclk         : serial clock
//   o_rise_tick    : high in the clk cycle whose edge raises o_sclk
//   o_fall_tick    : high in the clk cycle whose edge lowers o_sclk
module aes_spi_sclk_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_tick,
    output logic o_fall_tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          w_tc;

    assign w_tc        = i_en && (r_cnt == CW'(CLK_DIV - 1));
    assign o_rise_tick = w_tc && !r_sclk;
    assign o_fall_tick = w_tc && r_sclk;
    assign o_sclk      = r_sclk;

    always_ff @(posedge clk) begin
        if (reset || !i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else begin
            r_cnt  <= w_tc ? '0 : r_cnt + 1'b1;
            r_sclk <= w_tc ? !r_sclk : r_sclk;
        end
    end
endmodule

// File: rtl/aes_spi_sequencer.sv
// aes_spi_sequencer: runs one AES job over SPI (message, key out; result in) and pulses done
//   clk, reset          : system clock, synchronous active-high reset
//   start               : request strobe, sampled only when idle
//   req_mode/size/data/key : job request (key left-justified in req_key)
//   busy, done, err     : job status; done/err are one-clk pulses
//   result              : received 128-bit block
//   spi_sclk/cs_n/mosi/miso : SPI bus (SCLK idles low, MOSI changes on falling edge)
//   spi_mode, spi_size  : latched request fields, stable while spi_cs_n is low
// Optional SELF_CHECK_EN adds exp_data input and match output (result compare at done).
module aes_spi_sequencer
    import aes_spi_pkg::*;
#(
    parameter int CLK_DIV     = 50,
    parameter int WAIT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         req_mode,
    input  logic [1:0]   req_size,
    input  logic [127:0] req_data,
    input  logic [255:0] req_key,
`ifdef SELF_CHECK_EN
    input  logic [127:0] exp_data,
    output logic         match,
`endif
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] result,
    output logic         spi_sclk,
    output logic         spi_cs_n,
    output logic         spi_mosi,
    input  logic         spi_miso,
    output logic         spi_mode,
    output logic [1:0]   spi_size
);
    state_t       r_state;
    logic         r_busy;
    logic         r_done;
    logic         r_err;
    logic [127:0] r_result;
    logic         r_cs_n;
    logic         r_mosi;
    logic         r_mode;
    logic [1:0]   r_size;
    logic [127:0] r_msg;
    logic [255:0] r_key;
    logic [8:0]   r_bit;
`ifdef SELF_CHECK_EN
    logic [127:0] r_exp;
    logic         r_match;
`endif
    logic         w_rise;
    logic         w_fall;
    logic [8:0]   w_klen;
    logic [8:0]   w_bit_inc;

    aes_spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk        (clk),
        .reset      (reset),
        .i_en       (r_state != ST_IDLE),
        .o_sclk     (spi_sclk),
        .o_rise_tick(w_rise),
        .o_fall_tick(w_fall)
    );

    assign w_klen    = key_len(r_size);
    // bit counter never wraps: it parks at klen
    assign w_bit_inc = r_bit == w_klen ? r_bit : r_bit + 9'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_cs_n   <= 1'b1;
            r_mosi   <= 1'b0;
            r_mode   <= MODE_ENCR;
            r_size   <= SIZE_128;
            r_msg    <= '0;
            r_key    <= '0;
            r_bit    <= '0;
`ifdef SELF_CHECK_EN
            r_exp    <= '0;
            r_match  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && req_size == SIZE_ILL) begin
                        r_err <= 1'b1;
                    end else if (start) begin
                        r_state  <= ST_SETUP;
                        r_busy   <= 1'b1;
                        r_cs_n   <= 1'b0;
                        r_mosi   <= 1'b0;
                        r_mode   <= req_mode ? MODE_DECR : MODE_ENCR;
                        r_size   <= req_size;
                        r_msg    <= req_data;
                        // right-align the key so its first transmitted bit sits at [0]
                        r_key    <= req_key >> (9'd256 - key_len(req_size));
                        r_result <= '0;
                        r_bit    <= '0;
`ifdef SELF_CHECK_EN
                        r_exp    <= exp_data;
                        r_match  <= 1'b0;
`endif
                    end
                end
                ST_SETUP: begin
                    if (w_fall) begin
                        r_mosi  <= r_msg[0];
                        r_msg   <= r_msg >> 1;
                        r_state <= ST_MSG;
                    end
                end
                ST_MSG: begin
                    if (w_fall && r_bit == 9'd127) begin
                        r_mosi  <= r_key[0];
                        r_key   <= r_key >> 1;
                        r_bit   <= '0;
                        r_state <= ST_KEY;
                    end else if (w_fall) begin
                        r_mosi  <= r_msg[0];
                        r_msg   <= r_msg >> 1;
                        r_bit   <= w_bit_inc;
                    end
                end
                ST_KEY: begin
                    if (w_fall && r_bit == w_klen - 9'd1) begin
                        r_mosi  <= 1'b0;
                        r_bit   <= '0;
                        r_state <= ST_WAIT;
                    end else if (w_fall) begin
                        r_mosi  <= r_key[0];
                        r_key   <= r_key >> 1;
                        r_bit   <= w_bit_inc;
                    end
                end
                ST_WAIT: begin
                    if (w_fall) begin
                        r_bit   <= r_bit == 9'(WAIT_CYCLES - 1) ? '0 : w_bit_inc;
                        r_state <= r_bit == 9'(WAIT_CYCLES - 1) ? ST_RECV : ST_WAIT;
                    end
                end
                ST_RECV: begin
                    if (w_rise) begin
                        r_result <= {spi_miso, r_result[127:1]};
                        r_bit    <= w_bit_inc;
                    end
                    // leave on the falling edge that closes the last sampled period
                    if (w_fall && r_bit == 9'd128) begin
                        r_cs_n  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
`ifdef SELF_CHECK_EN
                    r_match <= r_result == r_exp;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign result   = r_result;
    assign spi_cs_n = r_cs_n;
    assign spi_mosi = r_mosi;
    assign spi_mode = r_mode;
    assign spi_size = r_size;
`ifdef SELF_CHECK_EN
    assign match    = r_match;
`endif
endmodule

// File: tb/tb_aes_spi_sequencer.sv
// tb_aes_spi_sequencer: directed jobs against a cycle-level SPI slave model with canned results
module tb_aes_spi_sequencer;
    localparam int CLK_DIV     = 2;
    localparam int WAIT_CYCLES = 4;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         start    = 1'b0;
    logic         req_mode = 1'b0;
    logic [1:0]   req_size = 2'b00;
    logic [127:0] req_data = '0;
    logic [255:0] req_key  = '0;
    logic [127:0] exp_data = '0;
    logic         spi_miso = 1'b0;
    logic         busy, done, err, spi_sclk, spi_cs_n, spi_mosi, spi_mode;
    logic [1:0]   spi_size;
    logic [127:0] result;
`ifdef SELF_CHECK_EN
    logic         match;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_spi_sequencer #(.CLK_DIV(CLK_DIV), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .req_mode(req_mode),
        .req_size(req_size),
        .req_data(req_data),
        .req_key (req_key),
`ifdef SELF_CHECK_EN
        .exp_data(exp_data),
        .match   (match),
`endif
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result),
        .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_mode(spi_mode),
        .spi_size(spi_size)
    );

    // Drives one job; the slave model records MOSI on each SCLK rise and presents the
    // canned result bit (result[0] first) after each SCLK fall.
    task automatic run_job(input string name, input logic mode, input logic [1:0] size,
                           input logic [127:0] data, input logic [255:0] key,
                           input logic [127:0] res, input logic [127:0] expd,
                           input bit spam, input int abort_rise);
        int klen, base, exp_lat, cyc, rises, dones, done_cyc, extra;
        logic prev_sclk, stable_ok, err_seen, aborted;
        logic [127:0] rx_data;
        logic [255:0] rx_key, exp_key;
        klen    = size == 2'b10 ? 256 : size == 2'b01 ? 192 : 128;
        base    = 1 + 128 + klen + WAIT_CYCLES;
        exp_lat = (base + 128) * 2 * CLK_DIV + 1;
        exp_key = key >> (256 - klen);
        rx_data = '0; rx_key = '0;
        rises = 0; dones = 0; done_cyc = -1; cyc = 0;
        prev_sclk = 1'b0; stable_ok = 1'b1; err_seen = 1'b0; aborted = 1'b0;
        @(negedge clk);
        req_mode = mode; req_size = size; req_data = data; req_key = key; exp_data = expd;
        start = 1'b1;
        @(posedge clk); #1;
        if (!spam) start = 1'b0;
        checks++;
        if (busy !== 1'b1 || result !== 128'h0 || spi_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b cs_n=%b result=%h, want busy=1 cs_n=0 result=0",
                     name, busy, spi_cs_n, result);
        end
`ifdef SELF_CHECK_EN
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL %s match_clear: got %b want 0", name, match);
        end
`endif
        while (cyc < 2600 && dones == 0) begin
            if (spam) begin
                req_mode = ~req_mode; req_size = req_size + 2'd1; req_data = ~req_data;
            end
            @(posedge clk); #1;
            cyc++;
            if (!spi_cs_n && (spi_mode !== mode || spi_size !== size)) stable_ok = 1'b0;
            if (err) err_seen = 1'b1;
            if (spi_sclk && !prev_sclk) begin
                if (rises >= 1 && rises <= 128) rx_data[rises-1] = spi_mosi;
                else if (rises >= 129 && rises < 129 + klen) rx_key[rises-129] = spi_mosi;
                rises++;
            end
            if (!spi_sclk && prev_sclk)
                spi_miso = (rises >= base && rises < base + 128) ? res[rises-base] : 1'b0;
            prev_sclk = spi_sclk;
            if (done) begin dones++; done_cyc = cyc; end
            if (abort_rise != 0 && rises == abort_rise) begin aborted = 1'b1; break; end
        end
        start = 1'b0;
        if (aborted) begin
            reset = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || busy !== 1'b0 || result !== 128'h0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s abort: cs_n=%b sclk=%b busy=%b done=%b result=%h, want 1 0 0 0 0",
                         name, spi_cs_n, spi_sclk, busy, done, result);
            end
            reset = 1'b0;
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (done || !spi_cs_n) extra++;
            end
            checks++;
            if (extra != 0) begin
                errors++;
                $display("FAIL %s abort_quiet: %0d active cycles, want 0", name, extra);
            end
            return;
        end
        checks++;
        if (dones != 1 || done_cyc != exp_lat) begin
            errors++;
            $display("FAIL %s latency: done at %0d (dones=%0d), want %0d", name, done_cyc, dones, exp_lat);
        end
        checks++;
        if (result !== res) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, result, res);
        end
        checks++;
        if (rx_data !== data) begin
            errors++;
            $display("FAIL %s mosi_data: got %h want %h", name, rx_data, data);
        end
        checks++;
        if (rx_key !== exp_key) begin
            errors++;
            $display("FAIL %s mosi_key: got %h want %h", name, rx_key, exp_key);
        end
        checks++;
        if (busy !== 1'b0 || stable_ok !== 1'b1 || err_seen !== 1'b0) begin
            errors++;
            $display("FAIL %s status: busy=%b stable=%b err_seen=%b, want 0 1 0", name, busy, stable_ok, err_seen);
        end
`ifdef SELF_CHECK_EN
        checks++;
        if (match !== (expd == res)) begin
            errors++;
            $display("FAIL %s match: got %b want %b", name, match, expd == res);
        end
`endif
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0 || result !== res) begin
            errors++;
            $display("FAIL %s hold: %0d extra active cycles, result %h, want 0 and %h", name, extra, result, res);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, spi_sclk, spi_cs_n, spi_mosi, spi_mode, spi_size} !== 9'b000010000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000010000",
                     {busy, done, err, spi_sclk, spi_cs_n, spi_mosi, spi_mode, spi_size});
        end
        checks++;
        if (result !== 128'h0) begin
            errors++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_encrypt_128;
        run_job("enc128", 1'b0, 2'b00, 128'h3243f6a8885a308d313198a2e0370734,
                {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3925841d02dc09fbdc118597196a0b32, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0, 0);
    endtask

    task automatic test_decrypt_256;
        run_job("dec256", 1'b1, 2'b10, 128'h8ea2b7ca516745bfeafc49904b496089,
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h00112233445566778899aabbccddeeff, 1'b0, 0);
    endtask

    task automatic test_err;
        @(negedge clk);
        req_size = 2'b11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || spi_cs_n !== 1'b1 || spi_sclk !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: err=%b busy=%b cs_n=%b sclk=%b, want 1 0 1 0", err, busy, spi_cs_n, spi_sclk);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || spi_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: err=%b busy=%b cs_n=%b, want 0 0 1", err, busy, spi_cs_n);
        end
    endtask

    task automatic test_reset_mid_key;
        run_job("abort192", 1'b0, 2'b01, 128'h00112233445566778899aabbccddeeff,
                {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h0, 1'b0, 179);
        run_job("enc192", 1'b0, 2'b01, 128'h00112233445566778899aabbccddeeff,
                {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h0, 1'b0, 0);
    endtask

    task automatic test_back_to_back;
        run_job("spam", 1'b1, 2'b00, 128'h3925841d02dc09fbdc118597196a0b32,
                {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h0, 1'b1, 0);
    endtask

`ifdef SELF_CHECK_EN
    task automatic test_self_check;
        test_encrypt_128;
        run_job("chk_dec", 1'b1, 2'b00, 128'h3925841d02dc09fbdc118597196a0b32,
                {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3243f6a8885a308d313198a2e0370734, 1'b0, 0);
        run_job("chk_bad", 1'b1, 2'b00, 128'h3925841d02dc09fbdc118597196a0b32,
                {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3243f6a8885a308d313198a2e0370735, 1'b0, 0);
    endtask
`endif

    initial begin
        test_reset;
        test_encrypt_128;
        test_decrypt_256;
        test_err;
        test_reset_mid_key;
        test_back_to_back;
`ifdef SELF_CHECK_EN
        test_self_check;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
